aes_shift_rows_pipe: RTL
========================

Name: aes_shift_rows_pipe

Overview:
Parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael round datapath. Direction is selected per beat, so one instance serves both the encrypt and decrypt round pipelines. Supports Rijndael block widths of 128, 192 and 256 bits through NB columns. Uses a valid/ready streaming handshake with a configurable register depth, and carries a sideband tag alongside the state. It sits between SubBytes and MixColumns in the round core.

Parameters:
NB, 4, state columns (legal 4, 6, 8); data width W = 32*NB; any other value is an elaboration error
STAGES, 1, pipeline register depth (legal 1..3)
TAG_W, 4, sideband tag width carried unmodified with each beat

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  block can accept a beat this cycle
mode_in  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt)
tag_in  in  TAG_W  sideband, e.g. round index or stream id
data_in  in  W  state, column-major, byte i at [W-1-8i -: 8]
valid_out  out  1  output beat valid
ready_out  in  1  downstream accepts the beat
mode_out  out  1  mode of the output beat
tag_out  out  TAG_W  tag of the output beat
data_out  out  W  transformed state

Behaviour:
- One clock. Reset is synchronous and active-high on port reset. Port names are clk and reset.
- Byte mapping: byte i sits at row r = i mod 4, column c = i div 4.
- Row shift offsets: row 0 = 0. Rows 1/2/3 = 1/2/3 for NB = 4 and NB = 6. Rows 1/2/3 = 1/3/4 for NB = 8.
- Encrypt: out(r,c) = in(r, (c + off_r) mod NB).
- Decrypt: out(r,c) = in(r, (c - off_r) mod NB).
- The permutation is purely a byte reorder and has no arithmetic. It is applied combinationally in front of stage 1. Stages 2..STAGES only carry data.
- Each stage k holds vld_k, mode_k, tag_k and data_k.
- Stage k loads from its upstream when vld_k = 0 or stage k is advancing. Stage STAGES advances when ready_out = 1.
- ready_in = (vld_1 = 0) or stage 1 advancing. The combinational ready chain from ready_out is permitted.
- A beat transfers on the input when valid_in and ready_in are both 1. It transfers on the output when valid_out and ready_out are both 1.
- Latency is exactly STAGES cycles when there is no stall. Throughput is 1 beat per cycle under continuous ready_out = 1.
- Stall (ready_out = 0 while valid_out = 1):
  - valid_out, data_out, mode_out and tag_out hold stable.
  - Up to STAGES beats are buffered.
  - No beat is dropped or duplicated.
- A stage that is not loaded holds its contents, including data, when its valid is 0. Data is not cleared on drain.
- Simultaneous input accept and output drain on a full pipe is allowed and must not create a bubble.
- Mode and tag travel with their beat. Mixed-mode back-to-back streams are legal, with no flush required between a mode change.
- Reset, including reset asserted mid-stream:
  - Next edge clears all vld_k, data_k, mode_k and tag_k to 0.
  - Therefore valid_out = 0, data_out = 0, mode_out = 0, tag_out = 0, and ready_in = 1 on the cycle after reset.
  - In-flight beats are discarded.
  - Inputs are ignored while reset = 1, and ready_in is 0 during reset.
- valid_out never asserts for data that was not accepted.
- valid_in may deassert at any time. After valid_in = 1 and ready_in = 0, the upstream holds its beat until accepted.

Test Plan:
- NB = 4, STAGES = 1, mode 0, data_in = d42711aee0bf98f1b8b45de51e415230 -> one cycle later data_out = d4bf5d30e0b452aeb84111f11e2798e5, valid_out = 1.
- NB = 4, mode 1, data_in = d4bf5d30e0b452aeb84111f11e2798e5 -> data_out = d42711aee0bf98f1b8b45de51e415230. Randomised enc-then-dec round trip returns the original state.
- NB = 8, mode 0, data_in bytes 00..1f -> out byte1 = 05, byte2 = 0e, byte3 = 13, byte4 = 04. Inverse restores 00..1f.
- STAGES = 3, 8 back-to-back beats alternating mode, tags 0..7, ready_out = 1 -> beats emerge in order, 3-cycle latency, no bubbles, mode_out and tag_out match each beat.
- STAGES = 2, ready_out = 0 for 5 cycles mid-stream -> output holds stable, ready_in drops after 2 beats are buffered. Release gives in-order delivery with no loss and no duplication.
- Reset asserted with 2 beats in flight -> next cycle valid_out = 0, data_out = 0, tag_out = 0, ready_in = 1. A beat applied after reset emerges normally.

Source files
------------

// File: rtl/aes_shift_rows_pipe.sv
// rtl/aes_shift_rows_pipe.sv - ShiftRows/InvShiftRows byte permutation with a valid/ready register pipeline
// Direction, tag and state travel together per beat; the permutation sits in front of stage 1.
module aes_shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4,
  localparam int W     = 32 * NB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             mode_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [W-1:0]     data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             mode_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [W-1:0]     data_out
);

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $error("aes_shift_rows_pipe: STAGES must be 1..3");
    end
  endgenerate

  // Rijndael-256 uses offsets 1/3/4 for rows 1/2/3; narrower blocks use the row index.
  function automatic int row_off(input int r);
    if (r == 0) return 0;
    if (NB == 8) return (r == 1) ? 1 : r + 1;
    return r;
  endfunction

  logic [W-1:0]     perm_data;

  logic             vld_q  [STAGES];
  logic             mode_q [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];
  logic [W-1:0]     data_q [STAGES];

  logic             vld_d  [STAGES];
  logic             mode_d [STAGES];
  logic [TAG_W-1:0] tag_d  [STAGES];
  logic [W-1:0]     data_d [STAGES];

  logic             src_vld  [STAGES];
  logic             src_mode [STAGES];
  logic [TAG_W-1:0] src_tag  [STAGES];
  logic [W-1:0]     src_data [STAGES];

  logic [STAGES-1:0] load_en;
  logic              chain;

  always_comb begin
    perm_data = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (mode_in)
          perm_data[W-1-8*(4*c+r) -: 8] = data_in[W-1-8*(4*((c+NB-row_off(r))%NB)+r) -: 8];
        else
          perm_data[W-1-8*(4*c+r) -: 8] = data_in[W-1-8*(4*((c+row_off(r))%NB)+r) -: 8];
      end
    end
  end

  // A stage may load when it is empty or its contents leave this cycle.
  always_comb begin
    chain   = ready_out;
    load_en = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain      = !vld_q[k] || chain;
      load_en[k] = chain;
    end
  end

  assign ready_in = !reset && load_en[0];

  always_comb begin
    src_vld[0]  = valid_in;
    src_mode[0] = mode_in;
    src_tag[0]  = tag_in;
    src_data[0] = perm_data;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_mode[k] = mode_q[k-1];
      src_tag[k]  = tag_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  // Payload only moves with a valid beat, so a draining stage keeps its last data.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k]  = vld_q[k];
      mode_d[k] = mode_q[k];
      tag_d[k]  = tag_q[k];
      data_d[k] = data_q[k];
      if (load_en[k]) begin
        vld_d[k] = src_vld[k];
        if (src_vld[k]) begin
          mode_d[k] = src_mode[k];
          tag_d[k]  = src_tag[k];
          data_d[k] = src_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= 1'b0;
        mode_q[k] <= 1'b0;
        tag_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k]  <= vld_d[k];
        mode_q[k] <= mode_d[k];
        tag_q[k]  <= tag_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign valid_out = vld_q[STAGES-1];
  assign mode_out  = mode_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];
  assign data_out  = data_q[STAGES-1];

endmodule
